// File: rtl/idelay_cal_pkg.sv
// Shared types and constants for the IDELAY tap calibration block.
package idelay_cal_pkg;

    localparam int unsigned TAP_W      = 9;
    localparam int unsigned WDOG_LIMIT = 1024;
    localparam int unsigned WDOG_W     = 10;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StCheck,
        StNext,
        StCenter,
        StDone,
        StFail
    } cal_state_e;

endpackage

// File: rtl/idelay_cal_run_track.sv
// Tracks the current and best run of good taps; the first longest run wins.
module idelay_cal_run_track
    import idelay_cal_pkg::*;
(
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               clear_i,
    input  logic               step_i,
    input  logic               good_i,
    input  logic [TAP_W-1:0]   tap_i,
    output logic [TAP_W-1:0]   fin_start_o,
    output logic [TAP_W:0]     fin_len_o
);

    logic [TAP_W-1:0] cur_start_q, cur_start_d;
    logic [TAP_W:0]   cur_len_q, cur_len_d;
    logic [TAP_W-1:0] best_start_q, best_start_d;
    logic [TAP_W:0]   best_len_q, best_len_d;
    logic             cur_wins;

    assign cur_wins = (cur_len_q > best_len_q);

    // Closing any still-open run is folded into the final view.
    assign fin_start_o = cur_wins ? cur_start_q : best_start_q;
    assign fin_len_o   = cur_wins ? cur_len_q : best_len_q;

    always_comb begin
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        if (clear_i) begin
            cur_start_d  = '0;
            cur_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end else if (step_i) begin
            if (good_i) begin
                if (cur_len_q == '0) begin
                    cur_start_d = tap_i;
                end
                cur_len_d = cur_len_q + 1'b1;
            end else begin
                if (cur_wins) begin
                    best_start_d = cur_start_q;
                    best_len_d   = cur_len_q;
                end
                cur_len_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

endmodule

// File: rtl/idelay_tap_cal.sv
// Sweeps delay taps, finds the widest window matching a training word and loads its center.
// Optional CHECK-state watchdog: define IDELAY_TAP_CAL_TIMEOUT_EN.
module idelay_tap_cal
    import idelay_cal_pkg::*;
#(
    parameter int unsigned         C_WIDTH     = 8,
    parameter logic [C_WIDTH-1:0]  C_PATTERN   = 8'hA5,
    parameter int unsigned         C_TAP_MAX   = 31,
    parameter int unsigned         C_SETTLE    = 8,
    parameter int unsigned         C_CHECK_LEN = 64,
    parameter int unsigned         C_MIN_EYE   = 4
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               start_i,
    input  logic [C_WIDTH-1:0] sample_i,
    input  logic               sample_vld_i,
    output logic               dly_ce_o,
    output logic               dly_inc_o,
    output logic               dly_ld_o,
    output logic [8:0]         dly_cntvalue_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               fail_o,
    output logic [8:0]         eye_center_o,
    output logic [8:0]         eye_width_o
);

    localparam int unsigned SW = $clog2(C_SETTLE + 1);
    localparam int unsigned CW = $clog2(C_CHECK_LEN + 1);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(C_SETTLE - 1);
    localparam logic [CW-1:0]    CHECK_LAST  = CW'(C_CHECK_LEN - 1);
    localparam logic [TAP_W-1:0] TAP_MAX     = TAP_W'(C_TAP_MAX);
    localparam logic [TAP_W:0]   MIN_EYE     = (TAP_W + 1)'(C_MIN_EYE);

    cal_state_e       state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [CW-1:0]    beat_q, beat_d;
    logic             good_q, good_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic             timeout_q, timeout_d;
    logic [TAP_W-1:0] center_q, center_d;
    logic [TAP_W-1:0] width_q, width_d;
`ifdef IDELAY_TAP_CAL_TIMEOUT_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

    logic             trk_clear, trk_step;
    logic [TAP_W-1:0] fin_start;
    logic [TAP_W:0]   fin_len;
    logic [TAP_W-1:0] center_calc;
    logic [TAP_W-1:0] width_sat;
    logic             pass;

    idelay_cal_run_track u_run_track (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .clear_i     (trk_clear),
        .step_i      (trk_step),
        .good_i      (good_q),
        .tap_i       (tap_q),
        .fin_start_o (fin_start),
        .fin_len_o   (fin_len)
    );

    assign center_calc = fin_start + TAP_W'(fin_len >> 1);
    // A full 512-tap window does not fit the 9-bit width output; saturate it.
    assign width_sat   = fin_len[TAP_W] ? '1 : fin_len[TAP_W-1:0];
    assign pass        = (fin_len >= MIN_EYE) && !timeout_q;

    always_comb begin
        state_d        = state_q;
        tap_d          = tap_q;
        settle_d       = settle_q;
        beat_d         = beat_q;
        good_d         = good_q;
        done_d         = done_q;
        fail_d         = fail_q;
        timeout_d      = timeout_q;
        center_d       = center_q;
        width_d        = width_q;
`ifdef IDELAY_TAP_CAL_TIMEOUT_EN
        wdog_d         = wdog_q;
`endif
        dly_ld_o       = 1'b0;
        dly_cntvalue_o = '0;
        trk_clear      = 1'b0;
        trk_step       = 1'b0;

        unique case (state_q)
            StIdle, StDone, StFail: begin
                if (start_i) begin
                    done_d    = 1'b0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                    tap_d     = '0;
                    trk_clear = 1'b1;
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                dly_ld_o       = 1'b1;
                dly_cntvalue_o = tap_q;
                settle_d       = '0;
                state_d        = StSettle;
            end
            StSettle: begin
                if (settle_q == SETTLE_LAST) begin
                    beat_d  = '0;
`ifdef IDELAY_TAP_CAL_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                    state_d = StCheck;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StCheck: begin
                if (sample_vld_i) begin
`ifdef IDELAY_TAP_CAL_TIMEOUT_EN
                    wdog_d = '0;
`endif
                    if (sample_i != C_PATTERN) begin
                        good_d  = 1'b0;
                        state_d = StNext;
                    end else if (beat_q == CHECK_LAST) begin
                        good_d  = 1'b1;
                        state_d = StNext;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
`ifdef IDELAY_TAP_CAL_TIMEOUT_EN
                else if (wdog_q == WDOG_W'(WDOG_LIMIT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = StCenter;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            StNext: begin
                trk_step = 1'b1;
                if (tap_q < TAP_MAX) begin
                    tap_d   = tap_q + 1'b1;
                    state_d = StLoad;
                end else begin
                    state_d = StCenter;
                end
            end
            StCenter: begin
                dly_ld_o = 1'b1;
                if (pass) begin
                    dly_cntvalue_o = center_calc;
                    center_d       = center_calc;
                    width_d        = width_sat;
                    done_d         = 1'b1;
                    state_d        = StDone;
                end else begin
                    center_d = '0;
                    width_d  = '0;
                    fail_d   = 1'b1;
                    state_d  = StFail;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= StIdle;
            tap_q     <= '0;
            settle_q  <= '0;
            beat_q    <= '0;
            good_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            center_q  <= '0;
            width_q   <= '0;
`ifdef IDELAY_TAP_CAL_TIMEOUT_EN
            wdog_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            settle_q  <= settle_d;
            beat_q    <= beat_d;
            good_q    <= good_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            center_q  <= center_d;
            width_q   <= width_d;
`ifdef IDELAY_TAP_CAL_TIMEOUT_EN
            wdog_q    <= wdog_d;
`endif
        end
    end

    assign dly_ce_o     = 1'b0;
    assign dly_inc_o    = 1'b0;
    assign busy_o       = !(state_q inside {StIdle, StDone, StFail});
    assign done_o       = done_q;
    assign fail_o       = fail_q;
    assign eye_center_o = center_q;
    assign eye_width_o  = width_q;

endmodule

// File: tb/tb_idelay_tap_cal.sv
// Directed-plus-random bench for idelay_tap_cal against a run-scanning reference model.
module tb_idelay_tap_cal;

    localparam logic [7:0] PAT = 8'hA5;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [7:0] sample;
    logic       vld;
    logic       dly_ce, dly_inc, dly_ld, busy, done, fail;
    logic [8:0] dly_cntvalue, eye_center, eye_width;

    int errors = 0;
    int checks = 0;
    bit good [0:31];
    int ld_cnt;
    int last_ld;

    idelay_tap_cal dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .start_i        (start),
        .sample_i       (sample),
        .sample_vld_i   (vld),
        .dly_ce_o       (dly_ce),
        .dly_inc_o      (dly_inc),
        .dly_ld_o       (dly_ld),
        .dly_cntvalue_o (dly_cntvalue),
        .busy_o         (busy),
        .done_o         (done),
        .fail_o         (fail),
        .eye_center_o   (eye_center),
        .eye_width_o    (eye_width)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bad_word();
        logic [7:0] flip;
        flip = 8'($urandom_range(255, 1));
        return PAT ^ flip;
    endfunction

    task automatic set_good(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) good[i] = 1'b1;
    endtask

    task automatic clear_good();
        for (int i = 0; i < 32; i++) good[i] = 1'b0;
    endtask

    // Reference: scan the tap map for the first longest run of good taps.
    task automatic model(output int exp_c, output int exp_w, output int exp_ok);
        int bs, bl, cs, cl;
        bs = 0; bl = 0; cs = 0; cl = 0;
        for (int t = 0; t <= 32; t++) begin
            if (t < 32 && good[t]) begin
                if (cl == 0) cs = t;
                cl++;
            end else begin
                if (cl > bl) begin
                    bs = cs;
                    bl = cl;
                end
                cl = 0;
            end
        end
        exp_ok = (bl >= 4) ? 1 : 0;
        exp_c  = exp_ok ? bs + bl / 2 : 0;
        exp_w  = exp_ok ? bl : 0;
    endtask

    // Emulates the delay line: after each load the lane is garbage while settling,
    // then returns the training word only on good taps.
    task automatic run_cal(input string tag, input int restart_tap);
        int cur_tap, since, cyc;
        int exp_c, exp_w, exp_ok;
        bit restarted, finished;
        cur_tap = 0; since = 100; restarted = 0; finished = 0;
        ld_cnt = 0; last_ld = -1;
        @(negedge clk);
        start = 1'b1;
        for (cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (ld_cnt > 0 && !busy) begin
                finished = 1;
                break;
            end
            if (dly_ld) begin
                ld_cnt++;
                cur_tap = int'(dly_cntvalue) % 32;
                last_ld = int'(dly_cntvalue);
                since = 0;
                if (cur_tap == restart_tap && !restarted) begin
                    start = 1'b1;
                    restarted = 1;
                end
            end else begin
                since++;
            end
            if (since <= 8) begin
                vld = 1'b1;
                sample = bad_word();
            end else begin
                vld = ($urandom_range(3) != 0);
                if (!vld) sample = 8'($urandom);
                else if (good[cur_tap]) sample = PAT;
                else sample = bad_word();
            end
        end
        vld = 1'b0;
        check({tag, " finished"}, 32'(finished), 1);
        model(exp_c, exp_w, exp_ok);
        check({tag, " done"}, 32'(done), 32'(exp_ok));
        check({tag, " fail"}, 32'(fail), 32'(!exp_ok));
        check({tag, " center"}, 32'(eye_center), 32'(exp_c));
        check({tag, " width"}, 32'(eye_width), 32'(exp_w));
        check({tag, " last_ld"}, 32'(last_ld), 32'(exp_c));
        check({tag, " ld_count"}, 32'(ld_cnt), 33);
    endtask

    initial begin
        int cyc, seen_ld;
        bit hit;
        rstn = 1'b0; start = 1'b0; vld = 1'b0; sample = '0;
        clear_good();
        #12;
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst fail", 32'(fail), 0);
        check("rst ld", 32'(dly_ld), 0);
        check("rst cnt", 32'(dly_cntvalue), 0);
        check("rst ce_inc", 32'({dly_ce, dly_inc}), 0);
        check("rst eye", 32'({eye_center, eye_width}), 0);
        @(negedge clk);
        rstn = 1'b1;

        clear_good(); set_good(10, 20);
        run_cal("eye10_20", -1);
        check("eye10_20 exact", 32'({eye_center, eye_width}), 32'({9'd15, 9'd11}));

        clear_good(); set_good(3, 6); set_good(20, 27);
        run_cal("two_runs", -1);
        check("two_runs exact", 32'(eye_center), 24);

        clear_good(); set_good(2, 5); set_good(9, 12);
        run_cal("tie_runs", -1);
        check("tie_runs exact", 32'(eye_center), 4);

        clear_good(); set_good(25, 31);
        run_cal("open_end", 5);
        check("open_end exact", 32'({eye_center, eye_width}), 32'({9'd28, 9'd7}));

        clear_good();
        run_cal("all_bad", -1);

        clear_good(); set_good(5, 7); set_good(12, 14);
        run_cal("short_eye", 20);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 32; i++) good[i] = ($urandom_range(3) != 0);
            run_cal("random", -1);
        end

        // Reset mid-CHECK at tap 12 aborts the sweep.
        clear_good(); set_good(10, 20);
        @(negedge clk);
        start = 1'b1;
        hit = 0;
        cyc = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            start = 1'b0;
            vld = 1'b1;
            sample = PAT;
            if (dly_ld && dly_cntvalue == 9'd12) begin
                hit = 1;
                cyc = 0;
            end
            if (hit) cyc++;
            if (hit && cyc == 20) break;
        end
        check("abort reached tap12", 32'(hit), 1);
        #2 rstn = 1'b0;
        #1;
        check("abort busy", 32'(busy), 0);
        check("abort ld", 32'({dly_ld, dly_cntvalue}), 0);
        @(posedge clk); #1;
        check("abort outs", 32'({busy, done, fail, dly_ld, eye_center, eye_width}), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        seen_ld = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dly_ld) seen_ld++;
        end
        check("abort no ld", 32'(seen_ld), 0);
        check("abort idle", 32'({busy, done, fail}), 0);

        // Lane never asserts valid in CHECK.
        vld = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef IDELAY_TAP_CAL_TIMEOUT_EN
        cyc = 0;
        while (!fail && cyc < 1200) begin
            @(negedge clk);
            cyc++;
        end
        check("wdog fail", 32'(fail), 1);
        check("wdog latency", 32'(cyc >= 1024), 1);
        check("wdog eye", 32'({eye_center, eye_width, done, busy}), 0);
`else
        repeat (1200) @(negedge clk);
        check("nowdog busy", 32'(busy), 1);
        check("nowdog flags", 32'({done, fail}), 0);
`endif
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
